// File: rtl/bnn_feeder_pkg.sv
// Shared definitions for the BNN stream feeder.
// Region select codes, run-state encoding and a width helper.
package bnn_feeder_pkg;

    localparam logic [1:0] SEL_PIX  = 2'd0;
    localparam logic [1:0] SEL_CONV = 2'd1;
    localparam logic [1:0] SEL_FC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Bits needed to index v entries (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/bnn_bit_store.sv
// Write-once bit RAM with auto-increment write pointer.
// Full flag sets after the last entry; later writes are dropped.
module bnn_bit_store
    import bnn_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;
    logic             r_full;

    // Storage array: contents need no reset.
    always_ff @(posedge clk) begin
        if (i_we && !r_full) r_mem[r_ptr] <= i_wdata;
    end

    // Write pointer and full flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_full <= 1'b0;
        end else if (i_we && !r_full) begin
            if (r_ptr == AW'(DEPTH - 1)) r_full <= 1'b1;
            else                         r_ptr  <= r_ptr + 1'b1;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;
    assign o_drop  = i_we && r_full;

endmodule

// File: rtl/bnn_stream_feeder.sv
// On-chip stimulus feeder for the BNN core: host loads three stores,
// then a run streams binarised pixels and serves conv/FC weight bits.
module bnn_stream_feeder
    import bnn_feeder_pkg::*;
#(
    parameter int IMG_PIX     = 784,
    parameter int PIX_W       = 8,
    parameter int THRESH      = 127,
    parameter int KTAPS       = 9,
    parameter int NUM_KERNELS = 2,
    parameter int NUM_CLASSES = 10,
    parameter int FC_LEN      = 288,
    localparam int DW = (PIX_W > NUM_CLASSES) ? PIX_W : NUM_CLASSES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [1:0]             wr_sel,
    input  logic [DW-1:0]          wr_data,
    input  logic                   start,
    input  logic [NUM_KERNELS-1:0] weight_en,
    input  logic                   fc_ivalid,
    input  logic                   done_in,
    input  logic [3:0]             classes_in,
    output logic                   pix_valid,
    output logic                   pix_out,
    output logic                   pix_last,
    output logic                   weight_conv_out,
    output logic [NUM_CLASSES-1:0] weight_fc_out,
    output logic                   busy,
    output logic                   loaded,
    output logic                   result_valid,
    output logic [3:0]             result,
    output logic                   err
);

    localparam int PA_W   = clog2(IMG_PIX);
    localparam int CDEPTH = NUM_KERNELS * KTAPS;
    localparam int CA_W   = clog2(CDEPTH);
    localparam int TP_W   = clog2(KTAPS);
    localparam int FP_W   = clog2(FC_LEN);

    state_t                 r_state, w_next;
    logic                   r_wr_ready;
    logic [PA_W-1:0]        r_pix_idx;
    logic [TP_W-1:0]        r_tp [NUM_KERNELS];
    logic [FP_W-1:0]        r_fp;
    logic                   r_conv_out;
    logic [NUM_CLASSES-1:0] r_fc_out;
    logic                   r_res_valid;
    logic [3:0]             r_result;
    logic                   r_err;

    logic                   w_wr, w_we_pix, w_we_conv, w_we_fc, w_sel_bad;
    logic                   w_pix_bit, w_pix_rd, w_conv_rd;
    logic [NUM_CLASSES-1:0] w_fc_rd;
    logic                   w_pix_full, w_conv_full, w_fc_full, w_loaded;
    logic                   w_pix_drop, w_conv_drop, w_fc_drop;
    logic                   w_run, w_start_ok, w_start_bad, w_done;
    logic                   w_conv_req, w_fc_req, w_multi, w_idle_req;
    logic                   w_last;
    logic [CA_W-1:0]        w_conv_addr;
    logic [NUM_KERNELS-1:0] w_kone;

    assign w_wr      = wr_valid && r_wr_ready;
    assign w_we_pix  = w_wr && (wr_sel == SEL_PIX);
    assign w_we_conv = w_wr && (wr_sel == SEL_CONV);
    assign w_we_fc   = w_wr && (wr_sel == SEL_FC);
    assign w_sel_bad = w_wr && (wr_sel == 2'd3);
    assign w_pix_bit = wr_data[PIX_W-1:0] > PIX_W'(THRESH);

    assign w_loaded    = w_pix_full && w_conv_full && w_fc_full;
    assign w_run       = (r_state != IDLE);
    assign w_start_ok  = start && (r_state == IDLE) && w_loaded;
    assign w_start_bad = start && (r_state == IDLE) && !w_loaded;
    assign w_done      = done_in && w_run;
    assign w_conv_req  = w_run && (|weight_en);
    assign w_fc_req    = w_run && fc_ivalid;
    assign w_multi     = w_run && ($countones(weight_en) > 1);
    assign w_idle_req  = !w_run && ((|weight_en) || fc_ivalid);
    assign w_last      = (r_pix_idx == PA_W'(IMG_PIX - 1));

    bnn_bit_store #(.DEPTH(IMG_PIX), .WIDTH(1)) u_pix (
        .clk(clk), .rstn(rstn), .i_we(w_we_pix), .i_wdata(w_pix_bit),
        .i_raddr(r_pix_idx), .o_rdata(w_pix_rd),
        .o_full(w_pix_full), .o_drop(w_pix_drop)
    );

    bnn_bit_store #(.DEPTH(CDEPTH), .WIDTH(1)) u_conv (
        .clk(clk), .rstn(rstn), .i_we(w_we_conv), .i_wdata(wr_data[0]),
        .i_raddr(w_conv_addr), .o_rdata(w_conv_rd),
        .o_full(w_conv_full), .o_drop(w_conv_drop)
    );

    bnn_bit_store #(.DEPTH(FC_LEN), .WIDTH(NUM_CLASSES)) u_fc (
        .clk(clk), .rstn(rstn), .i_we(w_we_fc),
        .i_wdata(wr_data[NUM_CLASSES-1:0]),
        .i_raddr(r_fp), .o_rdata(w_fc_rd),
        .o_full(w_fc_full), .o_drop(w_fc_drop)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; done_in overrides end-of-stream.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_next = STREAM;
            STREAM:  if (done_in) w_next = IDLE;
                     else if (w_last) w_next = HOLD;
            HOLD:    if (done_in) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Host port is open only while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_wr_ready <= 1'b0;
        else       r_wr_ready <= (w_next == IDLE);
    end

    // Pixel read index walks the image once per run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                         r_pix_idx <= '0;
        else if (w_start_ok || w_done)     r_pix_idx <= '0;
        else if (r_state == STREAM && !w_last)
            r_pix_idx <= r_pix_idx + 1'b1;
    end

    // Pick lowest requesting kernel and form its store address.
    always_comb begin
        w_conv_addr = '0;
        w_kone      = '0;
        for (int k = NUM_KERNELS - 1; k >= 0; k--) begin
            if (weight_en[k]) begin
                w_conv_addr = CA_W'(k * KTAPS) + CA_W'(r_tp[k]);
                w_kone      = '0;
                w_kone[k]   = 1'b1;
            end
        end
    end

    // Per-kernel tap pointers, wrapping so kernels replay.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_KERNELS; k++) r_tp[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (w_start_ok || w_done)
                    r_tp[k] <= '0;
                else if (w_conv_req && w_kone[k])
                    r_tp[k] <= (r_tp[k] == TP_W'(KTAPS - 1)) ?
                               '0 : r_tp[k] + 1'b1;
            end
        end
    end

    // FC pointer, wrapping over the FC length.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     r_fp <= '0;
        else if (w_start_ok || w_done) r_fp <= '0;
        else if (w_fc_req)
            r_fp <= (r_fp == FP_W'(FC_LEN - 1)) ? '0 : r_fp + 1'b1;
    end

    // Weight outputs update on request and hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_conv_out <= 1'b0;
            r_fc_out   <= '0;
        end else begin
            if (w_conv_req) r_conv_out <= w_conv_rd;
            if (w_fc_req)   r_fc_out   <= w_fc_rd;
        end
    end

    // Result capture; a new run clears the valid flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_start_ok) begin
            r_res_valid <= 1'b0;
        end else if (w_done) begin
            r_res_valid <= 1'b1;
            r_result    <= classes_in;
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_err <= 1'b0;
        else if (w_pix_drop || w_conv_drop || w_fc_drop || w_sel_bad ||
                 w_start_bad || w_idle_req || w_multi)
            r_err <= 1'b1;
    end

    assign wr_ready        = r_wr_ready;
    assign pix_valid       = (r_state == STREAM);
    assign pix_out         = pix_valid && w_pix_rd;
    assign pix_last        = pix_valid && w_last;
    assign weight_conv_out = r_conv_out;
    assign weight_fc_out   = r_fc_out;
    assign busy            = w_run;
    assign loaded          = w_loaded;
    assign result_valid    = r_res_valid;
    assign result          = r_result;
    assign err             = r_err;

endmodule
